// File: rtl/quotient_bcd_converter.sv
// quotient_bcd_converter
//   Sequential double-dabble converter placed after the divider. It accepts a
//   WIDTH-bit quotient (or a divide-by-zero flag) and produces DIGITS packed
//   BCD digits. It performs one adjust-and-shift step per clock.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     upstream quotient valid
//   in_ready     converter can accept a quotient this cycle (IDLE, not in reset)
//   in_data      binary quotient, WIDTH bits
//   in_div_zero  divisor was zero; takes priority over in_data
//   out_valid    BCD result available (DONE)
//   out_ready    downstream accepts the result
//   bcd          packed BCD; digit k in bits [4k+3:4k], digit 0 least significant
//   out_err      result belongs to a divide-by-zero
//   busy         conversion in progress (SHIFT)

module quotient_bcd_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_div_zero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  out_err,
   output logic                  busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [WIDTH-1:0]   bin_r;
   logic [BCD_W-1:0]   acc_r;
   logic [BCD_W-1:0]   adj_s;
   logic [BCD_W-1:0]   acc_next_s;
   logic [BCD_W-1:0]   bcd_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               err_r;
   logic               accept_s;
   logic               last_step_s;

   assign accept_s    = in_valid && in_ready;
   assign last_step_s = (cnt_r == CNT_W'(WIDTH - 1));
   assign bcd         = bcd_r;
   assign out_err     = err_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               // A zero divisor skips the conversion entirely.
               if (in_div_zero) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = SHIFT;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_step_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state.
   always_comb begin
      in_ready  = (state_r == IDLE) && !rst;
      busy      = (state_r == SHIFT);
      out_valid = (state_r == DONE);
   end

   // Double-dabble step: digits >= 5 get +3 (no inter-digit carry), then the
   // binary MSB shifts into digit 0 bit 0.
   always_comb begin
      adj_s = acc_r;
      for (int k = 0; k < DIGITS; k++) begin
         if (acc_r[4*k +: 4] >= 4'd5) begin
            adj_s[4*k +: 4] = acc_r[4*k +: 4] + 4'd3;
         end else begin
            adj_s[4*k +: 4] = acc_r[4*k +: 4];
         end
      end
      acc_next_s = {adj_s[BCD_W-2:0], bin_r[WIDTH-1]};
   end

   // Datapath registers. bcd_r is separate from the accumulator, so the
   // previous result stays on bcd while a new conversion runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_r <= {WIDTH{1'b0}};
         acc_r <= {BCD_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         bcd_r <= {BCD_W{1'b0}};
         err_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  if (in_div_zero) begin
                     bcd_r <= {BCD_W{1'b1}};
                     err_r <= 1'b1;
                  end else begin
                     bin_r <= in_data;
                     acc_r <= {BCD_W{1'b0}};
                     cnt_r <= {CNT_W{1'b0}};
                  end
               end
            end
            SHIFT: begin
               acc_r <= acc_next_s;
               bin_r <= bin_r << 1;
               cnt_r <= cnt_r + CNT_W'(1);
               if (last_step_s) begin
                  bcd_r <= acc_next_s;
                  err_r <= 1'b0;
               end
            end
            default: begin
               bin_r <= bin_r;
            end
         endcase
      end
   end

   quotient_bcd_converter_chk #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .in_ready  (in_ready),
      .busy      (busy),
      .out_valid (out_valid)
   );

endmodule

// quotient_bcd_converter_chk
//   Checks the DIGITS/WIDTH configuration and that the state-decoded
//   handshake outputs stay mutually exclusive.
// Ports: clk, rst, and the converter's in_ready, busy and out_valid.
module quotient_bcd_converter_chk #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input logic clk,
   input logic rst,
   input logic in_ready,
   input logic busy,
   input logic out_valid
);

   // True when 10^DIGITS exceeds the largest WIDTH-bit quotient.
   function automatic bit cfg_ok(input int w, input int d);
      logic [127:0] p10;
      logic [127:0] maxv;
      p10 = 128'd1;
      for (int i = 0; i < d; i++) begin
         p10 = p10 * 128'd10;
      end
      maxv = (128'd1 << w) - 128'd1;
      return p10 > maxv;
   endfunction

   localparam bit CFG_OK = cfg_ok(WIDTH, DIGITS);

   a_cfg: assert property (@(posedge clk) disable iff (rst) CFG_OK)
      else $error("quotient_bcd_converter: DIGITS too small for WIDTH");

   a_onehot: assert property (@(posedge clk) disable iff (rst)
      !(busy && out_valid) && !(in_ready && (busy || out_valid)))
      else $error("quotient_bcd_converter: conflicting state outputs");

endmodule

// File: doc/quotient_bcd_converter.md
Name: quotient_bcd_converter

Overview:
- Sequential double-dabble binary-to-BCD converter. It sits directly downstream of the division stage.
- It takes the WIDTH-bit quotient plus a divide-by-zero flag over a valid/ready handshake, and returns packed BCD digits for the display/readout stage.
- It runs one shift-and-adjust step per clock, so any WIDTH converts with no wide combinational logic.

Parameters:
- WIDTH, 8, bit width of the binary quotient input.
- DIGITS, 3, number of BCD output digits. It must satisfy 10^DIGITS > 2^WIDTH - 1. An illegal setting is a configuration error, flagged by simulation-time check.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream holds quotient valid.
- in_ready  output  1  block can accept a quotient this cycle.
- in_data  input  WIDTH  binary quotient from the divider.
- in_div_zero  input  1  upstream divisor was zero; sampled with in_data.
- out_valid  output  1  BCD result available.
- out_ready  input  1  downstream accepts the result.
- bcd  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
- out_err  output  1  result corresponds to a divide-by-zero.
- busy  output  1  conversion in progress (SHIFT state).

Behaviour:
- Reset (async, rst high): state IDLE, bcd=0, out_err=0, out_valid=0, busy=0. The binary shift register and step counter are cleared. in_ready=0 while rst is high and 1 in IDLE afterwards.
- FSM states: IDLE, SHIFT, DONE. Outputs are decoded from state:
  - in_ready = (IDLE && !rst).
  - busy = SHIFT.
  - out_valid = DONE.
- IDLE, accept on in_valid && in_ready at edge T:
  - If in_div_zero=0: load in_data into the binary shift register, clear the BCD accumulator, clear the counter, go to SHIFT.
  - If in_div_zero=1: set bcd to all ones (every digit 4'hF), set out_err=1, go straight to DONE. out_valid is visible in the cycle after T.
- SHIFT, once per clock:
  - Every BCD digit >= 5 gets +3 (each digit is a 4-bit add; no carry between digits).
  - Then shift {bcd_acc, bin} left by 1. The bin MSB enters digit 0 bit 0; bin LSB is filled with 0.
  - The counter increments. After exactly WIDTH steps go to DONE, with out_err=0.
- Latency: accept at edge T, then WIDTH SHIFT edges; out_valid=1 starting the cycle after edge T+WIDTH.
- DONE:
  - bcd and out_err are held stable while out_valid=1 && out_ready=0, for unbounded duration.
  - On out_ready=1 (handshake edge) go to IDLE.
- in_ready=0 in SHIFT and DONE. in_valid and in_data changes there are ignored, with no capture or queueing.
- Minimum spacing between acceptances is WIDTH+2 cycles (normal path) or 2 cycles (div-zero path).
- bcd and out_err retain their last values after the output handshake until the next conversion completes. Consumers must qualify them with out_valid.
- Counter width is clog2(WIDTH+1). The accumulator never overflows given the DIGITS constraint.
- Boundaries:
  - in_data=0 gives all-zero bcd after the full WIDTH cycles, with no early exit.
  - in_data=2^WIDTH-1 converts exactly.
  - in_div_zero has priority over in_data.
- Reset mid-operation (SHIFT or DONE): the conversion is abandoned immediately and all outputs return to reset values. No partial result is ever presented.

Test Plan:
- WIDTH=8, DIGITS=3, in_data=10, in_div_zero=0, out_ready=1 -> busy high for 8 cycles; out_valid high in cycle T+9 for one cycle; bcd=12'h010, out_err=0.
- in_data=255, then in_data=0 -> bcd=12'h255, then bcd=12'h000. Both take full latency; in_ready returns to 1 the cycle after each output handshake.
- in_div_zero=1, in_data=8'h5A -> out_valid in cycle T+1, bcd=12'hFFF, out_err=1. Next normal conversion of 16/3=5 gives bcd=12'h005, out_err=0.
- out_ready=0 for 5 cycles after in_data=99 completes -> out_valid, bcd=12'h099 and in_ready=0 stay stable. Toggle in_valid with in_data=7 during the stall: it is not captured. Raise out_ready: one handshake, then IDLE.
- Assert rst for 1 cycle at SHIFT step 4 of in_data=200 -> out_valid=0, bcd=0 and busy=0 immediately. After release, convert 199 -> bcd=12'h199 with correct latency.
- Exhaustive in_data 0..255 with random in_valid gaps and random out_ready back-pressure -> every bcd matches a decimal reference model; there are no lost or duplicated results.
